// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported main memory between the instruction-fetch (I) and data (D) ports.
// Fixed D priority with a starvation guard; one transaction at a time through IDLE -> ACCESS -> RESP.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4,
  localparam int SC_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic [DATA_W-1:0] IRdata,
  output logic              IReady,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  output logic [DATA_W-1:0] DRdata,
  output logic              DReady,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              Busy,
  output logic [1:0]        DbgState,
  output logic [SC_W-1:0]   DbgStarveCnt
);

  // Handshake: a requester raises Req with its fields stable and keeps them until its Ready pulse.
  // Ready is a single-cycle completion strobe; Req still high in the following IDLE is a new request.

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              wr_q, wr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    wr_d        = wr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (IReq || DReq) begin
          state_d  = S_ACCESS;
          cnt_d    = CNT_W'(MEM_LAT - 1);
          mem_en_d = 1'b1;
          // I wins when alone, or when D has beaten a waiting I STARVE_MAX times in a row.
          if (IReq && (!DReq || starve_q == SC_W'(STARVE_MAX))) begin
            owner_d    = OWN_I;
            starve_d   = '0;
            wr_d       = 1'b0;
            mem_addr_d = IAddr;
          end else begin
            owner_d     = OWN_D;
            wr_d        = DWe;
            mem_we_d    = DWe;
            mem_addr_d  = DAddr;
            mem_wdata_d = DWdata;
            if (IReq && starve_q != SC_W'(STARVE_MAX)) begin
              starve_d = starve_q + SC_W'(1);
            end
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          if (owner_q == OWN_I) begin
            i_rdata_d = MemRdata;
            i_ready_d = 1'b1;
          end else begin
            if (!wr_q) begin
              d_rdata_d = MemRdata;
            end
            d_ready_d = 1'b1;
          end
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_en_d = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      starve_q    <= '0;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign IRdata       = i_rdata_q;
  assign IReady       = i_ready_q;
  assign DRdata       = d_rdata_q;
  assign DReady       = d_ready_q;
  assign MemEn        = mem_en_q;
  assign MemWe        = mem_we_q;
  assign MemAddr      = mem_addr_q;
  assign MemWdata     = mem_wdata_q;
  assign Busy         = busy_q;
  assign DbgState     = state_q;
  assign DbgStarveCnt = starve_q;

endmodule
